// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO burst reader.
// Provides the FSM state encoding and a count minimum helper.
package fifo_rd_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    // Callers zero-extend their counts into 32 bits and truncate the
    // result back, so the comparison happens at the count's own width.
    function automatic logic [31:0] min_cnt(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer between the FIFO dequeue and the stream.
// Ports: clk_i/rst_i, push_i+din_i (write), pop_i (read),
//        dout_o (head entry), occ_o (entries held, 0..2).
module fifo_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   occ_q, occ_d;

    // The parent never pushes into a full buffer without popping,
    // and never pops an empty one.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) head_d = din_i;
                else               tail_d = din_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = din_i;
                end else begin
                    head_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign dout_o = head_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read master for first-word-fall-through FIFOs.
// Ports: CLK/RST; fifo_dot/emp/cnt in, fifo_deq out (FIFO side);
//        flush in, flush_done out; out_data/valid/ready/last stream.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_SIZE  = 4,
    parameter int FIFO_WIDTH = 32,
    parameter int BURST_LEN  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [FIFO_WIDTH-1:0] fifo_dot,
    input  logic                  fifo_emp,
    input  logic [FIFO_SIZE:0]    fifo_cnt,
    output logic                  fifo_deq,
    input  logic                  flush,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  flush_done
);

    localparam int CW = FIFO_SIZE + 1;
    localparam logic [CW-1:0] BLEN = CW'(BURST_LEN);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic [CW-1:0] flush_len;
    logic          req;
    logic          pop;
    logic [1:0]    occ;
    logic [FIFO_WIDTH:0] head;

    assign flush_len = CW'(min_cnt(32'(fifo_cnt), 32'(BLEN)));
    assign req       = flush | pend_q;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        pend_d   = pend_q | flush;
        done_d   = 1'b0;
        fifo_deq = ~RST & (state_q == S_BURST) & (rem_q != '0)
                 & ~fifo_emp & (occ != 2'd2);
        case (state_q)
            S_IDLE: begin
                if (fifo_cnt >= BLEN) begin
                    state_d = S_BURST;
                    rem_d   = BLEN;
                end else if (req && !fifo_emp) begin
                    state_d = S_BURST;
                    rem_d   = flush_len;
                end
            end
            S_BURST: begin
                if (fifo_deq) begin
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush completes only once nothing is left upstream or buffered.
        if (req && state_q == S_IDLE && fifo_emp
            && occ == 2'd0 && !fifo_deq) begin
            done_d = 1'b1;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    assign pop = out_valid & out_ready;

    fifo_skid_buf #(
        .W(FIFO_WIDTH + 1)
    ) u_buf (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (fifo_deq),
        .din_i  ({rem_q == ONE, fifo_dot}),
        .pop_i  (pop),
        .dout_o (head),
        .occ_o  (occ)
    );

    assign out_valid  = (occ != 2'd0);
    assign out_data   = head[FIFO_WIDTH-1:0];
    assign out_last   = head[FIFO_WIDTH] & out_valid;
    assign flush_done = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader with a queue-based FWFT FIFO.
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_fifo_burst_reader;

    localparam int FS = 4;
    localparam int FW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic [FW-1:0] fifo_dot;
    logic          fifo_emp;
    logic [FS:0]   fifo_cnt;
    logic          fifo_deq;
    logic          flush;
    logic [FW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          flush_done;

    typedef struct packed {
        logic          last;
        logic [FW-1:0] data;
    } exp_t;

    exp_t          expq[$];
    logic [FW-1:0] upq[$];

    int   compared   = 0;
    int   mismatched = 0;
    int   xfer_cnt   = 0;
    int   deq_total  = 0;
    int   fd_total   = 0;
    int   fd_bad     = 0;
    logic deq_cap    = 1'b0;

    fifo_burst_reader #(
        .FIFO_SIZE (FS),
        .FIFO_WIDTH(FW),
        .BURST_LEN (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .fifo_dot  (fifo_dot),
        .fifo_emp  (fifo_emp),
        .fifo_cnt  (fifo_cnt),
        .fifo_deq  (fifo_deq),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .flush_done(flush_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive_up();
        fifo_emp = (upq.size() == 0);
        fifo_cnt = (FS + 1)'(upq.size());
        if (fifo_emp) fifo_dot = '0;
        else          fifo_dot = upq[0];
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic cyc(input logic e, input logic [FW-1:0] w,
                       input logic fl);
        flush = fl;
        #1;
        deq_cap = fifo_deq;
        if (deq_cap) deq_total++;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        if (RST) begin
            upq.delete();
        end else begin
            if (deq_cap && upq.size() != 0) void'(upq.pop_front());
            if (e) upq.push_back(w);
        end
        drive_up();
        if (flush_done) begin
            fd_total++;
            if (out_valid) fd_bad++;
        end
    endtask

    task automatic enq(input logic [FW-1:0] w, input logic last);
        expq.push_back('{last: last, data: w});
        cyc(1'b1, w, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && expq.size() != 0; i++)
            cyc(1'b0, '0, 1'b0);
        chk(name, expq.size(), 0);
    endtask

    task automatic wait_xfer(input string name, input int n,
                             input int budget);
        for (int i = 0; i < budget && xfer_cnt < n; i++)
            cyc(1'b0, '0, 1'b0);
        chk(name, (xfer_cnt >= n), 1);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            compared++;
            if (out_last && !out_valid) begin
                mismatched++;
                $display("FAIL last_gate: out_last=1, expected 0 when idle");
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                compared++;
                if (expq.size() == 0) begin
                    mismatched++;
                    $display("FAIL extra_word: got data=%0d, expected none",
                             out_data);
                end else begin
                    e = expq.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        mismatched++;
                        $display("FAIL word: got %0d/last=%0b, expected %0d/last=%0b",
                                 out_data, out_last, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin
        int run;
        RST       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        fifo_emp  = 1'b0;
        fifo_cnt  = 5'd16;
        fifo_dot  = 32'hDEAD;

        // Reset with a full-looking FIFO must never dequeue.
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rst_deq", fifo_deq, 0);
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
        drive_up();
        cyc(1'b0, '0, 1'b0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_fdone", flush_done, 0);

        // Threshold burst of 8.
        deq_total = 0;
        for (int i = 1; i <= 8; i++) enq(i, i == 8);
        chk("thr_nodeq", deq_total, 0);
        xfer_cnt = 0;
        cyc(1'b0, '0, 1'b0);
        chk("thr_idle_deq", deq_cap, 0);
        run = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, 1'b0);
            if (deq_cap) run++;
        end
        chk("thr_deq_run", run, 8);
        cyc(1'b0, '0, 1'b0);
        chk("thr_deq_end", deq_cap, 0);
        chk("thr_xfers", xfer_cnt, 8);
        drain("thr_drain", 5);

        // Backpressure after two words.
        deq_total = 0;
        xfer_cnt  = 0;
        for (int i = 1; i <= 8; i++) enq(32'd20 + i, i == 8);
        wait_xfer("bp_wait2", 2, 20);
        out_ready = 1'b0;
        idle(4);
        chk("bp_deq_cnt", deq_total, 4);
        chk("bp_deq_stall", deq_cap, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_xfers", xfer_cnt, 2);
        out_ready = 1'b1;
        drain("bp_drain", 20);
        chk("bp_deq_all", deq_total, 8);

        // Flush a 3-word partial burst.
        deq_total = 0;
        fd_total  = 0;
        fd_bad    = 0;
        for (int i = 1; i <= 3; i++) enq(32'd40 + i, i == 3);
        idle(3);
        chk("fl_nodeq", deq_total, 0);
        cyc(1'b0, '0, 1'b1);
        drain("fl_drain", 20);
        idle(5);
        chk("fl_deq_cnt", deq_total, 3);
        chk("fl_done_cnt", fd_total, 1);
        chk("fl_done_empty", fd_bad, 0);

        // Flush on an empty FIFO.
        deq_total = 0;
        cyc(1'b0, '0, 1'b1);
        chk("fe_done_hi", flush_done, 1);
        cyc(1'b0, '0, 1'b0);
        chk("fe_done_lo", flush_done, 0);
        chk("fe_nodeq", deq_total, 0);

        // Streaming: two full bursts, tail held until flush.
        for (int i = 1; i <= 20; i++)
            enq(32'd100 + i, i == 8 || i == 16 || i == 20);
        for (int i = 0; i < 40 && expq.size() > 4; i++)
            cyc(1'b0, '0, 1'b0);
        idle(5);
        chk("st_held", expq.size(), 4);
        chk("st_idle_valid", out_valid, 0);
        fd_total = 0;
        cyc(1'b0, '0, 1'b1);
        drain("st_drain", 20);
        idle(5);
        chk("st_done_cnt", fd_total, 1);

        // Streaming again, with reset in the middle of burst two.
        xfer_cnt = 0;
        for (int i = 1; i <= 20; i++)
            enq(32'd200 + i, i == 8 || i == 16 || i == 20);
        cyc(1'b0, '0, 1'b1);
        wait_xfer("mr_wait", 11, 40);
        RST = 1'b1;
        cyc(1'b0, '0, 1'b0);
        chk("mr_valid", out_valid, 0);
        chk("mr_last", out_last, 0);
        chk("mr_fdone", flush_done, 0);
        chk("mr_deq", fifo_deq, 0);
        expq.delete();
        RST = 1'b0;
        fd_total = 0;
        cyc(1'b0, '0, 1'b0);
        chk("mr_idle_deq", deq_cap, 0);
        idle(3);
        chk("mr_pend_clr", fd_total, 0);
        for (int i = 1; i <= 8; i++) enq(32'd300 + i, i == 8);
        drain("mr_fresh", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the team's first-word-fall-through FIFOs (DFIFO / SRL_FIFO).
- Consumes the FIFO's dot/emp/cnt outputs and drives its deq input.
- Dequeues in bursts of BURST_LEN words, or in a shorter flush burst on request.
- Presents the words on a valid/ready stream through a 2-entry output buffer, with an end-of-burst marker.

Parameters:
- FIFO_SIZE, 4, log2 of the upstream FIFO depth; fifo_cnt is FIFO_SIZE+1 bits.
- FIFO_WIDTH, 32, data width in bits.
- BURST_LEN, 8, words per threshold burst; legal range 1..2^FIFO_SIZE.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- fifo_dot  in  FIFO_WIDTH  FIFO head word, valid whenever fifo_emp=0.
- fifo_emp  in  1  FIFO empty.
- fifo_cnt  in  FIFO_SIZE+1  FIFO occupancy.
- fifo_deq  out  1  dequeue strobe to the FIFO.
- flush  in  1  one-cycle pulse: drain the FIFO even if below threshold.
- out_data  out  FIFO_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks the last word of each burst.
- flush_done  out  1  one-cycle pulse: flush completed.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset values:
  - state IDLE, remaining=0, buffer occupancy occ=0, flush_pend=0.
  - out_valid=0, out_last=0, out_data=0, flush_done=0.
  - fifo_deq is combinational and forced to 0 while RST=1.
- State machine, states IDLE and BURST.
  - IDLE, threshold: if fifo_cnt >= BURST_LEN, go to BURST with remaining=BURST_LEN. The threshold has priority over flush.
  - IDLE, flush: else if (flush | flush_pend) and fifo_emp=0, go to BURST with remaining = min(fifo_cnt, BURST_LEN). Width rule: compare at FIFO_SIZE+1 bits.
  - BURST: fifo_deq = (remaining != 0) & ~fifo_emp & (occ < 2).
  - Each deq decrements remaining. On the deq that makes remaining 0, the popped word is tagged last and the state returns to IDLE.
  - A new burst may start the cycle after returning to IDLE, even while the buffer is still draining.
- flush_pend:
  - Set by flush.
  - Cleared when flush_done fires.
  - A flush arriving while flush_pend=1 is absorbed (no second pulse).
- flush_done:
  - Registered output.
  - Asserted for one cycle after an edge at which all of the following hold: (flush | flush_pend), state IDLE, fifo_emp=1, occ=0, no deq.
  - Flush on an already-empty FIFO gives flush_done one cycle after flush.
- Output buffer: 2-entry FIFO of {last, data}.
  - Push on fifo_deq; pop on out_valid & out_ready. Push and pop in the same cycle is legal; occ is unchanged.
  - out_valid = (occ != 0). out_data and out_last show the head entry.
  - Latency: a word dequeued at edge t is visible on out_data after edge t, i.e. the cycle after fifo_deq is high.
  - Throughput: one word per cycle when out_ready is held high.
- Backpressure: while occ=2 and no pop, fifo_deq=0. No word is dropped or duplicated; order is strictly preserved.
- fifo_deq never asserts while fifo_emp=1, even if remaining > 0. This is defensive: the upstream FIFO is assumed to have no other reader.
- Reset mid-burst:
  - The burst is abandoned, buffered words are discarded, and flush_pend is cleared.
  - The upstream FIFO shares RST, so no stale data survives reset.
- out_last is high only together with out_valid.

Decomposition:
- Shared package fifo_rd_pkg:
  - state encoding localparams S_IDLE, S_BURST;
  - min function on FIFO_SIZE+1-bit counts.
- One sub-module: fifo_skid_buf.
  - Parameterized 2-entry buffer, width FIFO_WIDTH+1.
  - Exposes occ, or a full/empty pair, to the parent.
- The FSM and counters stay in fifo_burst_reader.

Test Plan:
- Reset: hold RST 4 cycles with fifo_emp=0, fifo_cnt=16 → fifo_deq=0 throughout. After release, out_valid, out_last and flush_done are 0 at the first edge.
- Threshold burst: enqueue 1..8 upstream, out_ready=1.
  - fifo_deq stays low until fifo_cnt=8.
  - Then 8 consecutive deq cycles, and out_data=1..8 on consecutive cycles starting one cycle after the first deq.
  - out_last is high only with 8.
- Backpressure: 8-word burst with out_ready=0 after word 2.
  - occ reaches 2 and fifo_deq drops.
  - Raising out_ready resumes delivery: words 3..8 arrive in order with no gaps or repeats.
- Flush short burst: 3 words (cnt=3), flush pulse.
  - A burst of 3 is delivered, with out_last on word 3.
  - flush_done pulses once, the cycle after the buffer empties.
- Flush on empty FIFO: flush pulse → flush_done high exactly one cycle later, no fifo_deq.
- Streaming and mid-burst reset:
  - Enqueue 1..20 at one per cycle → two bursts (out_last on 8 and 16). Words 17..20 are held until flush, then delivered with out_last on 20.
  - Repeat with RST asserted mid-second-burst → outputs clear the next cycle and state returns to IDLE.
